// File: rtl/acc_seq_ctrl.sv
// Command sequencer for the buffered-output accumulator: turns LOAD/ADD/ADDN/READ
// commands into registered en/ldacc/oe strobes and returns a response per command.
module acc_seq_ctrl #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [CNT_W-1:0]  cmd_cnt,
  output logic              acc_en,
  output logic              acc_ldacc,
  output logic              acc_oe,
  output logic              bus_oe,
  output logic [DATA_W-1:0] bus_out,
  input  logic [DATA_W-1:0] bus_in,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_op,
  output logic [DATA_W-1:0] rsp_data,
  output logic [2:0]        dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
  // the offering side holds valid and its payload stable until that edge.

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_ADDN = 2'b10;
  localparam logic [1:0] OP_READ = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_EXEC   = 3'd1,
    S_REPEAT = 3'd2,
    S_READ   = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t            state;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  counter;

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      op_q      <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      counter   <= '0;
      cmd_ready <= 1'b0;
      acc_en    <= 1'b0;
      acc_ldacc <= 1'b0;
      acc_oe    <= 1'b0;
      bus_oe    <= 1'b0;
      bus_out   <= '0;
      rsp_valid <= 1'b0;
      rsp_op    <= '0;
      rsp_data  <= '0;
    end else begin
      // Strobes are re-asserted each cycle by the state that owns them.
      acc_en    <= 1'b0;
      acc_ldacc <= 1'b0;
      acc_oe    <= 1'b0;
      bus_oe    <= 1'b0;
      bus_out   <= '0;
      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            op_q      <= cmd_op;
            data_q    <= cmd_data;
            cnt_q     <= cmd_cnt;
            cmd_ready <= 1'b0;
            case (cmd_op)
              OP_LOAD, OP_ADD: begin
                state     <= S_EXEC;
                bus_oe    <= 1'b1;
                bus_out   <= cmd_data;
                acc_en    <= 1'b1;
                acc_ldacc <= (cmd_op == OP_ADD);
              end
              OP_ADDN: begin
                if (cmd_cnt != '0) begin
                  state     <= S_REPEAT;
                  counter   <= cmd_cnt;
                  bus_oe    <= 1'b1;
                  bus_out   <= cmd_data;
                  acc_en    <= 1'b1;
                  acc_ldacc <= 1'b1;
                end else begin
                  state     <= S_RESP;
                  rsp_valid <= 1'b1;
                  rsp_op    <= cmd_op;
                end
              end
              default: begin
                state  <= S_READ;
                acc_oe <= 1'b1;
              end
            endcase
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        S_EXEC: begin
          state     <= S_RESP;
          rsp_valid <= 1'b1;
          rsp_op    <= op_q;
        end
        S_REPEAT: begin
          // counter holds the pulses still to come including the current one.
          if (counter == CNT_W'(1)) begin
            state     <= S_RESP;
            counter   <= '0;
            rsp_valid <= 1'b1;
            rsp_op    <= op_q;
          end else begin
            counter   <= counter - CNT_W'(1);
            bus_oe    <= 1'b1;
            bus_out   <= data_q;
            acc_en    <= 1'b1;
            acc_ldacc <= 1'b1;
          end
        end
        S_READ: begin
          state     <= S_RESP;
          rsp_data  <= bus_in;
          rsp_valid <= 1'b1;
          rsp_op    <= op_q;
        end
        S_RESP: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Bench for acc_seq_ctrl: an accumulator/bus environment model, a command driver,
// and a response monitor scoring against an arithmetic reference of the command stream.
module tb_acc_seq_ctrl;

  localparam int EW = 29;  // {op, rdata, pulses, latency, ldacc, operand}

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_data = 8'h00;
  logic [3:0] cmd_cnt = 4'h0;
  logic       acc_en, acc_ldacc, acc_oe, bus_oe;
  logic [7:0] bus_out;
  logic [7:0] bus_in;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [1:0] rsp_op;
  logic [7:0] rsp_data;
  logic [2:0] dbg_state;

  acc_seq_ctrl #(.DATA_W(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_cnt(cmd_cnt),
    .acc_en(acc_en), .acc_ldacc(acc_ldacc), .acc_oe(acc_oe),
    .bus_oe(bus_oe), .bus_out(bus_out), .bus_in(bus_in),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op),
    .rsp_data(rsp_data), .dbg_state(dbg_state)
  );

  // ---------------- clock / environment ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [7:0] env_acc = 8'h5A;  // the accumulator register itself, never reset
  always @(posedge clk)
    if (acc_en) env_acc <= acc_ldacc ? env_acc + (bus_oe ? bus_out : 8'h00)
                                     : (bus_oe ? bus_out : 8'h00);
  assign bus_in = acc_oe ? env_acc : (bus_oe ? bus_out : 8'h00);

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            t0_q[$];
  int            checks = 0;
  int            errors = 0;
  logic [7:0]    ref_acc = 8'h00;
  logic [7:0]    last_read = 8'h00;
  int            pulses = 0;
  bit            in_rsp = 0;
  logic [1:0]    held_op;
  logic [7:0]    held_data;
  bit            prev_bus_oe = 0;
  int            force_low = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- driver ----------------
  task automatic issue(input logic [1:0] op, input logic [7:0] d, input logic [3:0] c);
    int n;
    logic [4:0] np, lt;
    logic ld;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_cnt = c;
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      check("accept_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    np = 5'd1; lt = 5'd2; ld = 1'b0;
    case (op)
      2'b00: ref_acc = d;
      2'b01: begin ref_acc = ref_acc + d; ld = 1'b1; end
      2'b10: begin
        ref_acc = 8'((int'(ref_acc) + int'(d) * int'(c)) % 256);
        np = 5'(c); lt = 5'(int'(c) + 1); ld = 1'b1;
      end
      default: begin last_read = ref_acc; np = 5'd0; end
    endcase
    exp_q.push_back({op, last_read, np, lt, ld, d});
    t0_q.push_back(cyc + 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_data = 8'($urandom); cmd_cnt = 4'($urandom);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst_n) begin
      check("oe_overlap", 32'(acc_oe && bus_oe), 32'd0);
      if (acc_oe) check("oe_gap", 32'(prev_bus_oe), 32'd0);
      if (!bus_oe) check("bus_out_idle", 32'(bus_out), 32'd0);
      prev_bus_oe = bus_oe;
      if (acc_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_en", 32'(acc_en), 32'd0);
        end else begin
          e = exp_q[0];
          pulses++;
          check("en_bus_oe", 32'(bus_oe), 32'd1);
          check("en_bus_out", 32'(bus_out), 32'(e[7:0]));
          check("en_ldacc", 32'(acc_ldacc), 32'(e[8]));
        end
      end
      if (rsp_valid) begin
        check("cmd_ready_in_resp", 32'(cmd_ready), 32'd0);
        if (!in_rsp) begin
          if (exp_q.size() == 0) begin
            check("unexpected_rsp", 32'(rsp_valid), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("rsp_op", 32'(rsp_op), 32'(e[28:27]));
            check("rsp_data", 32'(rsp_data), 32'(e[26:19]));
            check("en_pulses", 32'(pulses), 32'(e[18:14]));
            check("latency", 32'(cyc + 1 - t0_q.pop_front()), 32'(e[13:9]));
          end
          pulses = 0;
          in_rsp = 1;
          held_op = rsp_op;
          held_data = rsp_data;
        end else begin
          check("rsp_op_stable", 32'(rsp_op), 32'(held_op));
          check("rsp_data_stable", 32'(rsp_data), 32'(held_data));
        end
      end else if (in_rsp) begin
        check("rsp_dropped", 32'(rsp_valid), 32'd1);
        in_rsp = 0;
      end
    end
    if (rsp_valid && rst_n) begin
      if (force_low > 0) begin
        rsp_ready = 1'b0;
        force_low--;
      end else begin
        rsp_ready = ($urandom_range(0, 3) != 0);
      end
      if (rsp_ready) in_rsp = 0;
    end else begin
      rsp_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] pre;
    int n;
    #12;
    check("reset_outputs", {cmd_ready, acc_en, acc_ldacc, acc_oe, bus_oe, rsp_valid, bus_out},
          32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(cmd_ready), 32'd1);

    issue(2'b00, 8'h25, 4'd0); issue(2'b11, 8'h00, 4'd0);               // LOAD / READ
    issue(2'b00, 8'hF0, 4'd0); issue(2'b01, 8'h20, 4'd0); issue(2'b11, 8'h00, 4'd0);
    issue(2'b00, 8'h03, 4'd0); issue(2'b10, 8'h05, 4'd4); issue(2'b11, 8'h00, 4'd0);
    issue(2'b00, 8'h11, 4'd0); issue(2'b10, 8'hAA, 4'd0); issue(2'b11, 8'h00, 4'd0);

    force_low = 5;                                                        // response stall
    issue(2'b11, 8'h00, 4'd0); issue(2'b01, 8'h01, 4'd0); issue(2'b11, 8'h00, 4'd0);

    for (int i = 0; i < 150; i++)
      issue(2'($urandom_range(0, 3)), 8'($urandom), 4'($urandom_range(0, 15)));

    n = 0;
    while ((exp_q.size() != 0 || in_rsp) && n < 200) begin @(negedge clk); n++; end
    check("drain", 32'(exp_q.size()), 32'd0);

    pre = ref_acc;                                                        // reset mid-ADDN
    issue(2'b10, 8'h05, 4'd8);
    n = 0;
    while (pulses < 2 && n < 50) begin @(negedge clk); #1; n++; end
    check("addn_started", 32'(pulses), 32'd2);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          {cmd_ready, acc_en, acc_ldacc, acc_oe, bus_oe, rsp_valid, bus_out}, 32'd0);
    check("partial_addn", 32'(env_acc), 32'(pre + 8'h05));
    exp_q.delete(); t0_q.delete();
    pulses = 0; in_rsp = 0; prev_bus_oe = 0; last_read = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rerelease", 32'(cmd_ready), 32'd1);
    repeat (3) begin
      @(negedge clk);
      check("no_stale_rsp", 32'(rsp_valid), 32'd0);
    end
    issue(2'b11, 8'h00, 4'd0);                      // first READ after reset sees k=1 additions
    issue(2'b00, 8'h7E, 4'd0); issue(2'b10, 8'h02, 4'd3); issue(2'b11, 8'h00, 4'd0);

    n = 0;
    while ((exp_q.size() != 0 || in_rsp) && n < 200) begin @(negedge clk); n++; end
    check("final_drain", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  // The first READ after the reset needs the partially-updated accumulator as reference.
  always @(posedge rst_n) if (cyc > 5) ref_acc = env_acc;

endmodule
